// File: rtl/tnn_pkg.sv
// Shared types and constants for the ternary neuron datapath.
// Activation encoding, FSM states and popcount width.
package tnn_pkg;
  localparam int PC_W = 3;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  typedef enum logic {
    ACC,
    DONE
  } state_t;
endpackage

// File: rtl/tnn_act_thresh.sv
// Threshold activation for one neuron sum.
// TNN_TERNARY_OUT_EN selects ternary output; default is binary.
module tnn_act_thresh
  import tnn_pkg::*;
#(
  parameter int ACC_W = 6
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic [1:0]              act
);

`ifdef TNN_TERNARY_OUT_EN
  // The +1 test wins when thr_lo > thr_hi.
  always_comb begin
    act = ACT_ZERO;
    if (sum >= thr_hi)
      act = ACT_POS;
    else if (sum < thr_lo)
      act = ACT_NEG;
  end
`else
  logic unused_thr_lo;
  assign unused_thr_lo = ^thr_lo;

  always_comb begin
    act = ACT_NEG;
    if (sum >= thr_hi)
      act = ACT_POS;
  end
`endif

endmodule

// File: rtl/tnn_neuron_accum.sv
// Accumulates (pos - neg) popcounts over N_BEATS and activates.
// TNN_TERNARY_OUT_EN enables ternary activation via thr_lo.
module tnn_neuron_accum
  import tnn_pkg::*;
#(
  parameter int N_BEATS = 4,
  parameter int ACC_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_pos,
  input  logic [2:0]       in_neg,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_act,
  output logic [ACC_W-1:0] out_sum
);

  localparam int CNT_W = $clog2(N_BEATS) + 1;

  if (N_BEATS < 1) begin : g_bad_beats
    $error("N_BEATS must be at least 1");
  end
  if (N_BEATS * 7 > 2 ** (ACC_W - 1) - 1) begin : g_bad_width
    $error("ACC_W too narrow for N_BEATS");
  end

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] delta;
  logic signed [ACC_W-1:0] fin;
  logic [CNT_W-1:0]        beat_cnt;
  logic [1:0]              act;
  logic                    take;
  logic                    last;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign take      = in_valid & in_ready;
  assign last      = (beat_cnt == CNT_W'(N_BEATS - 1));

  // Popcounts are unsigned; zero-extend before the signed subtract.
  assign delta = $signed({{(ACC_W-PC_W){1'b0}}, in_pos})
               - $signed({{(ACC_W-PC_W){1'b0}}, in_neg});
  assign fin   = acc + delta;

  tnn_act_thresh #(
    .ACC_W (ACC_W)
  ) u_act (
    .sum    (fin),
    .thr_hi (thr_hi),
    .thr_lo (thr_lo),
    .act    (act)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:  if (take && last) state_nxt = DONE;
      DONE: if (out_ready)    state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      beat_cnt <= '0;
      out_act  <= '0;
      out_sum  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        if (last) begin
          acc      <= '0;
          beat_cnt <= '0;
          out_sum  <= fin;
          out_act  <= act;
        end else begin
          acc      <= fin;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule
